uart_tx_stim: RTL and testbench
===============================

UART_TX_STIM -- requirements
Module: uart_tx_stim

Interface
REQ-001 Parameter DIV_RATE, default 260, clock cycles per UART bit (10 MHz / 38400 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte-entry transmit queue depth; power of two, 2..16.
REQ-003 clk  input  1  single clock; every flop samples on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  byte write strobe, sampled each posedge.
REQ-006 wr_data  input  8  byte to queue, valid when wr_en=1.
REQ-007 full  output  1  queue holds FIFO_DEPTH bytes.
REQ-008 empty  output  1  queue holds zero bytes.
REQ-009 tx_busy  output  1  frame in progress (state != IDLE).
REQ-010 tx_end  output  1  one-cycle pulse on the last cycle of a stop bit.
REQ-011 tx  output  1  serial line driven into the chip's uart_rx pin; idle high.

Function
REQ-012 Frame format: 8N1, one low start bit, 8 data bits LSB first, one high stop bit; 10*DIV_RATE cycles per frame.
REQ-013 A write is accepted iff wr_en=1 and full=0 at the sampling edge; a write while full is dropped with no state change.
REQ-014 full/empty reflect the registered count; a pop in the same cycle does not make a full-cycle write acceptable.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; if empty=0, pop head byte into the shift register and enter START at the next edge.
REQ-017 START: tx=0 for DIV_RATE cycles, then DATA.
REQ-018 DATA: tx=shift[0] for DIV_RATE cycles per bit; shift right after each bit; 3-bit bit index; enter STOP after bit 7.
REQ-019 STOP: tx=1 for DIV_RATE cycles; tx_end=1 on the final cycle; then IDLE.
REQ-020 Baud counter counts 0..DIV_RATE-1 and clears on each state change.
REQ-021 Latency: tx, tx_busy and tx_end are registered; a write accepted at edge E0 into an idle, empty block drives tx low after edge E1.
REQ-022 Back-to-back frames: after STOP, IDLE lasts exactly one cycle before the next START when the queue is non-empty.
REQ-023 Simultaneous write and pop update count by net zero and preserve data order.
REQ-024 Read and write pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-025 When reset=1 at an edge: state=IDLE, tx=1, tx_busy=0, tx_end=0, full=0, empty=1, pointers, count and counters=0.
REQ-026 A reset asserted mid-frame aborts the frame (tx=1 after that edge) and discards queued bytes; no partial stop bit is emitted.
REQ-027 wr_en is ignored during a reset cycle.

Structure
REQ-028 The shared UART header holds UART_DIV_RATE, UART_BIT_CNT_MSB (7), and the IDLE/START/DATA/STOP state encodings, shared with uart_rx.
REQ-029 Queue storage and pointers go in one sub-module, uart_tx_fifo (ports: clk, reset, push, push_data, pop, pop_data, full, empty).
REQ-030 The FSM, baud counter and shift register live in uart_tx_stim.

Verification
REQ-031 DIV_RATE=4: write 0x55 at E0 -> tx low after E1; sequence 0,1,0,1,0,1,0,1,0,1 in 4-cycle bits; tx_end pulses at cycle 40 of the frame.
REQ-032 DIV_RATE=4, idle: write 0x01..0x06 on 6 consecutive edges -> count peaks at 4, 0x06 is dropped, and 0x01..0x05 arrive in order at a looped-back uart_rx with one idle cycle between frames.
REQ-033 Write 0xA3 and assert reset during DATA bit 3 -> tx=1, empty=1 and tx_busy=0 after that edge; no tx_end pulse.
REQ-034 Hold wr_en=1 with full=1 while a pop occurs in the same cycle -> that byte is dropped and count drops by one.
REQ-035 Default DIV_RATE=260: write 0x0A -> tx low for exactly 260 cycles, frame lasts 2600 cycles, and the uart_rx model prints a newline.

Source files
------------

// File: rtl/uart_tx_stim_pkg.sv
// Shared UART definitions: default baud divisor, data-bit index limit and the
// transmitter/receiver state encodings.
package uart_tx_stim_pkg;

   localparam int unsigned UART_DIV_RATE    = 260;  // 10 MHz / 38400 baud
   localparam int unsigned UART_BIT_CNT_MSB = 7;    // last data bit index
   localparam int unsigned UART_DATA_W      = 8;
   localparam int unsigned UART_BAUD_W      = 16;   // holds DIV_RATE-1 up to 65534
   localparam int unsigned UART_BIT_W       = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage : uart_tx_stim_pkg

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the UART transmitter.
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write strobe and byte (ignored while full)
//   pop             : remove head byte (ignored while empty)
//   pop_data        : current head byte
//   full, empty     : registered occupancy flags
module uart_tx_fifo
   import uart_tx_stim_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [UART_DATA_W-1:0] push_data,
   input  logic                   pop,
   output logic [UART_DATA_W-1:0] pop_data,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   full_q, empty_q;
   logic                   push_ok, pop_ok;
   logic [UART_DATA_W-1:0] mem_q [DEPTH];

   // Acceptance uses the registered flags only, so a same-cycle pop never
   // makes room for a write presented while full.
   assign push_ok = push && !full_q;
   assign pop_ok  = pop && !empty_q;

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control registers; flags are precomputed from the next count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CW'(DEPTH));
         empty_q  <= (count_d == '0);
      end
   end

   // Storage array; contents need no reset since the pointers gate access.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = empty_q;

endmodule : uart_tx_fifo

// File: rtl/uart_tx_stim.sv
// Queued 8N1 UART transmitter used to stimulate a uart_rx input.
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : byte write strobe (dropped while full)
//   wr_data    : byte to queue
//   full/empty : queue occupancy flags
//   tx_busy    : frame in progress
//   tx_end     : pulse on the final cycle of the stop bit
//   tx         : serial output, idle high
module uart_tx_stim
   import uart_tx_stim_pkg::*;
#(
   parameter int unsigned DIV_RATE   = UART_DIV_RATE,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [UART_DATA_W-1:0] wr_data,
   output logic                   full,
   output logic                   empty,
   output logic                   tx_busy,
   output logic                   tx_end,
   output logic                   tx
);

   localparam logic [UART_BAUD_W-1:0] BAUD_LAST = UART_BAUD_W'(DIV_RATE - 1);
   localparam logic [UART_BIT_W-1:0]  BIT_LAST  = UART_BIT_W'(UART_BIT_CNT_MSB);

   uart_state_e            state_q, state_d;
   logic [UART_BAUD_W-1:0] baud_q, baud_d;
   logic [UART_BIT_W-1:0]  bit_q, bit_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   end_q, end_d;
   logic                   baud_done;
   logic                   fifo_pop;
   logic                   fifo_empty;
   logic [UART_DATA_W-1:0] fifo_data;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (full),
      .empty     (fifo_empty)
   );

   assign baud_done = (baud_q == BAUD_LAST);

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         end_q   <= end_d;
      end
   end

   // Next-state logic. Outputs are derived from the next state so the
   // registered tx lines up with state_q cycle for cycle.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q + UART_BAUD_W'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      tx_d     = 1'b1;
      busy_d   = 1'b0;
      end_d    = 1'b0;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_data;
               state_d  = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
               bit_d   = bit_q + UART_BIT_W'(1);
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
      // Fires when the next cycle is the last one of the stop bit.
      end_d  = (state_d == STOP) && (baud_d == BAUD_LAST);
   end

   assign empty   = fifo_empty;
   assign tx_busy = busy_q;
   assign tx_end  = end_q;
   assign tx      = tx_q;

endmodule : uart_tx_stim

// File: tb/tb_uart_tx_stim.sv
// Bench for uart_tx_stim: a fast instance (DIV_RATE=4) and a default instance
// (DIV_RATE=260). Stimulus pushes expected bytes; per-instance uart_rx models
// decode frames and compare against the queued expectations.
module tb_uart_tx_stim;

   logic       clk;
   logic       reset;
   logic [1:0] wr_en_v;
   logic [7:0] wr_data0, wr_data1;
   logic [1:0] full_v, empty_v, busy_v, end_v, tx_v;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         abort_cnt [2];
   logic [7:0] exp0 [$];
   logic [7:0] exp1 [$];
   int         fs0 [$];
   int         fs1 [$];

   uart_tx_stim #(.DIV_RATE(4), .FIFO_DEPTH(4)) dut_fast (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_v[0]),
      .wr_data (wr_data0),
      .full    (full_v[0]),
      .empty   (empty_v[0]),
      .tx_busy (busy_v[0]),
      .tx_end  (end_v[0]),
      .tx      (tx_v[0])
   );

   uart_tx_stim dut_dflt (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_v[1]),
      .wr_data (wr_data1),
      .full    (full_v[1]),
      .empty   (empty_v[1]),
      .tx_busy (busy_v[1]),
      .tx_end  (end_v[1]),
      .tx      (tx_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_size(input int idx);
      return (idx == 0) ? exp0.size() : exp1.size();
   endfunction

   // uart_rx model: decodes one frame per falling start edge and checks the
   // exact waveform, busy flag and tx_end position against the expected byte.
   task automatic rx_monitor(input int idx, input int div);
      logic [7:0] got, want;
      logic       have, aborted, exp_bit;
      int         bad_shape, bad_end, bitn, ph;
      forever begin
         @(negedge clk);
         if (reset || tx_v[idx] !== 1'b0) continue;
         if (idx == 0) fs0.push_back(cyc); else fs1.push_back(cyc);
         have = (exp_size(idx) != 0);
         want = 8'h00;
         if (have) want = (idx == 0) ? exp0[0] : exp1[0];
         got = 8'h00; bad_shape = 0; bad_end = 0; aborted = 1'b0;
         for (int c = 1; c <= 10 * div; c++) begin
            if (c > 1) @(negedge clk);
            if (reset) begin
               aborted = 1'b1;
               break;
            end
            bitn = (c - 1) / div;
            ph   = (c - 1) % div;
            if (bitn >= 1 && bitn <= 8 && ph == div / 2) got[bitn-1] = tx_v[idx];
            if (bitn == 0)      exp_bit = 1'b0;
            else if (bitn == 9) exp_bit = 1'b1;
            else                exp_bit = want[bitn-1];
            if (tx_v[idx] !== exp_bit || busy_v[idx] !== 1'b1) bad_shape++;
            if (end_v[idx] !== ((c == 10 * div) ? 1'b1 : 1'b0)) bad_end++;
         end
         if (aborted) begin
            abort_cnt[idx]++;
            check($sformatf("rx%0d_abort_no_tx_end", idx), 32'(bad_end), 32'd0);
         end else if (!have) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx%0d_unexpected_frame: got byte 0x%0h, expected no frame", idx, got);
         end else begin
            check($sformatf("rx%0d_byte", idx), 32'(got), 32'(want));
            check($sformatf("rx%0d_frame_shape", idx), 32'(bad_shape), 32'd0);
            check($sformatf("rx%0d_tx_end_pos", idx), 32'(bad_end), 32'd0);
            if (idx == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
            if (idx == 1 && got == 8'h0A) $display("[RX1] received 0x0a: newline");
         end
      end
   endtask

   initial begin
      abort_cnt[0] = 0;
      abort_cnt[1] = 0;
      fork
         rx_monitor(0, 4);
         rx_monitor(1, 260);
      join
   end

   // Wait until an instance is idle, drained and all expected frames are seen.
   task automatic wait_done(input int idx, input int maxc);
      int n = 0;
      while (n < maxc && !(busy_v[idx] === 1'b0 && empty_v[idx] === 1'b1 && exp_size(idx) == 0)) begin
         @(posedge clk); #1;
         n++;
      end
      n_tests++;
      if (n >= maxc) begin
         n_fail++;
         $display("FAIL wait_done_%0d: timed out after %0d cycles, busy=%b empty=%b pending=%0d",
                  idx, n, busy_v[idx], empty_v[idx], exp_size(idx));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bad;
      reset    = 1'b1;
      wr_en_v  = 2'b00;
      wr_data0 = 8'h00;
      wr_data1 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx",    32'(tx_v),    32'h3);
      check("rst_busy",  32'(busy_v),  32'h0);
      check("rst_end",   32'(end_v),   32'h0);
      check("rst_full",  32'(full_v),  32'h0);
      check("rst_empty", 32'(empty_v), 32'h3);
      reset = 1'b0;

      // Single frame 0x55: latency and idle-to-start timing.
      @(posedge clk); #1;
      wr_en_v[0] = 1'b1; wr_data0 = 8'h55; exp0.push_back(8'h55);
      @(posedge clk); #1;                       // E0
      wr_en_v[0] = 1'b0;
      check("t1_empty_E0", 32'(empty_v[0]), 32'd0);
      check("t1_tx_E0",    32'(tx_v[0]),    32'd1);
      @(posedge clk); #1;                       // E1
      check("t1_tx_E1",    32'(tx_v[0]),    32'd0);
      check("t1_busy_E1",  32'(busy_v[0]),  32'd1);
      check("t1_empty_E1", 32'(empty_v[0]), 32'd1);
      wait_done(0, 200);
      check("t1_tx_idle",  32'(tx_v[0]),    32'd1);

      // Six consecutive writes: fifth fills the queue, sixth is dropped.
      fs0.delete();
      for (int i = 1; i <= 6; i++) begin
         wr_en_v[0] = 1'b1; wr_data0 = 8'(i);
         if (i <= 5) exp0.push_back(8'(i));
         @(posedge clk); #1;
         if (i == 4) check("t2_full_cnt3",  32'(full_v[0]), 32'd0);
         if (i == 5) check("t2_full_cnt4",  32'(full_v[0]), 32'd1);
         if (i == 6) check("t2_full_drop",  32'(full_v[0]), 32'd1);
      end
      wr_en_v[0] = 1'b0;
      wait_done(0, 400);
      check("t2_frames", 32'(fs0.size()), 32'd5);
      for (int k = 1; k < fs0.size(); k++)
         check($sformatf("t2_gap%0d", k), 32'(fs0[k] - fs0[k-1]), 32'd41);

      // Reset during data bit 3 of 0xA3 aborts the frame; wr_en ignored.
      @(posedge clk); #1;
      wr_en_v[0] = 1'b1; wr_data0 = 8'hA3; exp0.push_back(8'hA3);
      @(posedge clk); #1;                       // E0
      wr_en_v[0] = 1'b0;
      repeat (17) @(posedge clk);
      #1;                                       // E17: bit 3
      check("t3_bit3", 32'(tx_v[0]), 32'd0);
      reset = 1'b1; wr_en_v[0] = 1'b1; wr_data0 = 8'h77;
      @(posedge clk); #1;                       // E18: reset sampled
      reset = 1'b0; wr_en_v[0] = 1'b0;
      exp0.delete();
      check("t3_tx",    32'(tx_v[0]),    32'd1);
      check("t3_empty", 32'(empty_v[0]), 32'd1);
      check("t3_busy",  32'(busy_v[0]),  32'd0);
      check("t3_end",   32'(end_v[0]),   32'd0);
      bad = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (tx_v[0] !== 1'b1 || end_v[0] !== 1'b0) bad++;
      end
      check("t3_quiet", 32'(bad), 32'd0);
      check("t3_abort_seen", 32'(abort_cnt[0]), 32'd1);

      // Write held while full across a pop: that write is dropped.
      for (int i = 0; i < 5; i++) begin
         wr_en_v[0] = 1'b1; wr_data0 = 8'(8'h10 + i); exp0.push_back(8'(8'h10 + i));
         @(posedge clk); #1;
      end
      check("t4_full", 32'(full_v[0]), 32'd1);
      wr_data0 = 8'hEE;
      n = 0;
      while (full_v[0] === 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      wr_en_v[0] = 1'b0;
      check("t4_pop_edge", 32'(n), 32'd38);
      check("t4_full_after", 32'(full_v[0]), 32'd0);
      check("t4_empty_after", 32'(empty_v[0]), 32'd0);
      wait_done(0, 400);

      // Default divisor: newline byte, 260-cycle bits, 2600-cycle frame.
      @(posedge clk); #1;
      wr_en_v[1] = 1'b1; wr_data1 = 8'h0A; exp1.push_back(8'h0A);
      @(posedge clk); #1;                       // E0
      wr_en_v[1] = 1'b0;
      check("t5_tx_E0", 32'(tx_v[1]), 32'd1);
      @(posedge clk); #1;                       // E1
      check("t5_tx_E1", 32'(tx_v[1]), 32'd0);
      n = 0;
      while (busy_v[1] === 1'b1 && n < 3000) begin
         n++;
         @(posedge clk); #1;
      end
      check("t5_busy_len", 32'(n), 32'd2600);
      check("t5_rx_done", 32'(exp1.size()), 32'd0);
      check("t5_tx_idle", 32'(tx_v[1]), 32'd1);
      wait_done(1, 100);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_tx_stim
